// File: rtl/prga_decrypt_op_if.sv
// Bundle of the start/done handshake and the three memory ports (S RAM, encrypted ROM,
// decrypted RAM) seen by the RC4 PRGA/decrypt stage; master = the stage, slave = memories/controller.
interface prga_decrypt_op_if;
  logic       start;
  logic       done;
  logic       key_valid;

  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] s_rddata;

  logic [4:0] enc_addr;
  logic [7:0] enc_rddata;

  logic [4:0] dec_addr;
  logic [7:0] dec_wrdata;
  logic       dec_wren;

  modport master (
    input  start,
    input  s_rddata,
    input  enc_rddata,
    output done,
    output key_valid,
    output s_addr,
    output s_wrdata,
    output s_wren,
    output enc_addr,
    output dec_addr,
    output dec_wrdata,
    output dec_wren
  );

  modport slave (
    output start,
    output s_rddata,
    output enc_rddata,
    input  done,
    input  key_valid,
    input  s_addr,
    input  s_wrdata,
    input  s_wren,
    input  enc_addr,
    input  dec_addr,
    input  dec_wrdata,
    input  dec_wren
  );
endinterface

// File: rtl/prga_decrypt_op.sv
// RC4 PRGA + decrypt: walks S, XORs each keystream byte with the encrypted ROM, writes plaintext RAM.
// Fixed 8 cycles per byte; start is a level sampled in IDLE/DONE; optional early abort on a non-[a-z ] byte.
module prga_decrypt_op #(
  parameter int MSG_LEN     = 32,
  parameter int CHECK_ASCII = 1
) (
  input  logic              clk,
  input  logic              reset,
  prga_decrypt_op_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_SI,
    ST_LATCH_SI,
    ST_READ_SJ,
    ST_LATCH_SJ,
    ST_WRITE_SI,
    ST_WRITE_SJ,
    ST_READ_F,
    ST_LATCH_F,
    ST_DONE
  } state_e;

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [4:0] k_q, k_d;
  logic       key_valid_q, key_valid_d;

  // Only meaningful in LATCH_F, where both memories return the bytes addressed in READ_F.
  logic [7:0] plain_byte;
  logic       plain_ok;
  assign plain_byte = bus.s_rddata ^ bus.enc_rddata;
  assign plain_ok   = (plain_byte == 8'h20) || ((plain_byte >= 8'h61) && (plain_byte <= 8'h7A));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      k_q         <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      k_q         <= k_d;
      key_valid_q <= key_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    k_d         = k_q;
    key_valid_d = key_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          i_d         = 8'd1;
          j_d         = 8'd0;
          k_d         = 5'd0;
          key_valid_d = 1'b0;
          state_d     = ST_READ_SI;
        end
      end
      ST_READ_SI:  state_d = ST_LATCH_SI;
      ST_LATCH_SI: begin
        si_d    = bus.s_rddata;
        j_d     = j_q + bus.s_rddata;
        state_d = ST_READ_SJ;
      end
      ST_READ_SJ:  state_d = ST_LATCH_SJ;
      ST_LATCH_SJ: begin
        sj_d    = bus.s_rddata;
        state_d = ST_WRITE_SI;
      end
      ST_WRITE_SI: state_d = ST_WRITE_SJ;
      ST_WRITE_SJ: state_d = ST_READ_F;
      ST_READ_F:   state_d = ST_LATCH_F;
      ST_LATCH_F: begin
        // The byte is written regardless; the check only decides whether to continue.
        if ((CHECK_ASCII != 0) && !plain_ok) begin
          key_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if (k_q == LAST_K) begin
          key_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          k_d     = k_q + 5'd1;
          i_d     = i_q + 8'd1;
          state_d = ST_READ_SI;
        end
      end
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [7:0] s_addr_c;
  logic [7:0] s_wrdata_c;
  logic       s_wren_c;
  logic [4:0] enc_addr_c;
  logic [4:0] dec_addr_c;
  logic [7:0] dec_wrdata_c;
  logic       dec_wren_c;

  // The swap sum si+sj is unchanged by the swap, so the keystream index uses the latched pair.
  always_comb begin
    s_addr_c     = '0;
    s_wrdata_c   = '0;
    s_wren_c     = 1'b0;
    enc_addr_c   = '0;
    dec_addr_c   = '0;
    dec_wrdata_c = '0;
    dec_wren_c   = 1'b0;
    case (state_q)
      ST_READ_SI:  s_addr_c = i_q;
      ST_READ_SJ:  s_addr_c = j_q;
      ST_WRITE_SI: begin
        s_addr_c   = i_q;
        s_wrdata_c = sj_q;
        s_wren_c   = 1'b1;
      end
      ST_WRITE_SJ: begin
        s_addr_c   = j_q;
        s_wrdata_c = si_q;
        s_wren_c   = 1'b1;
      end
      ST_READ_F: begin
        s_addr_c   = si_q + sj_q;
        enc_addr_c = k_q;
      end
      ST_LATCH_F: begin
        dec_addr_c   = k_q;
        dec_wrdata_c = plain_byte;
        dec_wren_c   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done       = (state_q == ST_DONE);
  assign bus.key_valid  = key_valid_q;
  assign bus.s_addr     = s_addr_c;
  assign bus.s_wrdata   = s_wrdata_c;
  assign bus.s_wren     = s_wren_c;
  assign bus.enc_addr   = enc_addr_c;
  assign bus.dec_addr   = dec_addr_c;
  assign bus.dec_wrdata = dec_wrdata_c;
  assign bus.dec_wren   = dec_wren_c;

endmodule

// File: tb/tb_prga_decrypt_op.sv
// Bench for prga_decrypt_op: three instances (len 4 no-check, len 4 check, len 32 check) on
// behavioural memories, compared against a plain-array RC4 reference.
module tb_prga_decrypt_op;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0] start_r;
  logic [2:0] load;
  logic [2:0] done_w, kv_w, s_wren_w, dec_wren_w;
  logic [7:0] s_addr_w     [3];
  logic [7:0] s_wrdata_w   [3];
  logic [4:0] enc_addr_w   [3];
  logic [4:0] dec_addr_w   [3];
  logic [7:0] dec_wrdata_w [3];
  logic [7:0] s_rd         [3];
  logic [7:0] enc_rd       [3];

  logic [7:0] s_mem   [3][256];
  logic [7:0] s_init  [3][256];
  logic [7:0] enc_mem [3][32];
  logic [7:0] dec_mem [3][32];
  int         s_wr_cnt   [3];
  int         dec_wr_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    prga_decrypt_op_if bus ();
    assign bus.start      = start_r[g];
    assign bus.s_rddata   = s_rd[g];
    assign bus.enc_rddata = enc_rd[g];
    assign done_w[g]       = bus.done;
    assign kv_w[g]         = bus.key_valid;
    assign s_wren_w[g]     = bus.s_wren;
    assign dec_wren_w[g]   = bus.dec_wren;
    assign s_addr_w[g]     = bus.s_addr;
    assign s_wrdata_w[g]   = bus.s_wrdata;
    assign enc_addr_w[g]   = bus.enc_addr;
    assign dec_addr_w[g]   = bus.dec_addr;
    assign dec_wrdata_w[g] = bus.dec_wrdata;

    prga_decrypt_op #(
      .MSG_LEN     ((g == 2) ? 32 : 4),
      .CHECK_ASCII ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Synchronous memories with one-cycle read latency; load re-initialises S and blanks the plaintext RAM.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      s_rd[g]   <= s_mem[g][s_addr_w[g]];
      enc_rd[g] <= enc_mem[g][enc_addr_w[g]];
      if (load[g]) begin
        for (int a = 0; a < 256; a++) s_mem[g][a] <= s_init[g][a];
        for (int a = 0; a < 32; a++) dec_mem[g][a] <= 8'hEE;
        s_wr_cnt[g]   <= 0;
        dec_wr_cnt[g] <= 0;
      end else begin
        if (s_wren_w[g]) begin
          s_mem[g][s_addr_w[g]] <= s_wrdata_w[g];
          s_wr_cnt[g]           <= s_wr_cnt[g] + 1;
        end
        if (dec_wren_w[g]) begin
          dec_mem[g][dec_addr_w[g]] <= dec_wrdata_w[g];
          dec_wr_cnt[g]             <= dec_wr_cnt[g] + 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_s0  [256];
  logic [7:0] m_s   [256];
  logic [7:0] m_enc [32];
  logic [7:0] m_dec [32];
  logic [7:0] ks    [32];
  int         m_n;
  bit         m_kv;

  function automatic bit is_text(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Textbook RC4 PRGA over a plain array, followed by the per-byte text check.
  task automatic ref_model(input int len, input bit chk_ascii);
    int i, j;
    logic [7:0] t, b;
    for (int a = 0; a < 256; a++) m_s[a] = m_s0[a];
    for (int a = 0; a < 32; a++) m_dec[a] = 8'hEE;
    i = 0; j = 0; m_n = 0; m_kv = 1'b0;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      b = m_enc[k] ^ m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
      m_dec[k] = b;
      m_n = k + 1;
      if (chk_ascii && !is_text(b)) break;
      if (k == len - 1) m_kv = 1'b1;
    end
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) m_s0[a] = 8'(a);
  endtask

  task automatic set_random_perm();
    logic [7:0] t;
    int r;
    set_identity();
    for (int a = 255; a > 0; a--) begin
      r = $urandom_range(a, 0);
      t = m_s0[a]; m_s0[a] = m_s0[r]; m_s0[r] = t;
    end
  endtask

  task automatic gen_keystream();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'h00;
    ref_model(32, 1'b0);
    for (int k = 0; k < 32; k++) ks[k] = m_dec[k];
  endtask

  function automatic logic [7:0] rand_text();
    int r;
    r = $urandom_range(26, 0);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    b = 8'($urandom_range(255, 0));
    while (is_text(b)) b = 8'($urandom_range(255, 0));
    return b;
  endfunction

  task automatic load_mem(input int g);
    for (int a = 0; a < 256; a++) s_init[g][a] = m_s0[a];
    for (int k = 0; k < 32; k++) enc_mem[g][k] = m_enc[k];
    @(negedge clk); load[g] = 1'b1;
    @(negedge clk); load[g] = 1'b0;
  endtask

  int         last_edges;
  logic       last_kv1;
  logic [7:0] last_a1, last_a3;

  // Raise start, then count edges after the sampling edge until done (bounded).
  task automatic do_run(input int g);
    @(negedge clk); start_r[g] = 1'b1;
    @(posedge clk); #1;
    last_edges = 0;
    last_kv1   = kv_w[g];
    last_a1    = s_addr_w[g];
    last_a3    = 8'h00;
    while (!done_w[g] && last_edges < 300) begin
      @(posedge clk); #1;
      last_edges++;
      if (last_edges == 2) last_a3 = s_addr_w[g];
    end
  endtask

  task automatic run_check(input int g, input int hold, input string tag);
    int len;
    len = (g == 2) ? 32 : 4;
    ref_model(len, g != 0);
    load_mem(g);
    do_run(g);
    chk({tag, "_edges"}, last_edges, 8 * m_n);
    chk({tag, "_kv"}, 32'(kv_w[g]), 32'(m_kv));
    for (int k = 0; k < 32; k++) chk({tag, "_dec"}, 32'(dec_mem[g][k]), 32'(m_dec[k]));
    for (int a = 0; a < 256; a++) chk({tag, "_s"}, 32'(s_mem[g][a]), 32'(m_s[a]));
    chk({tag, "_s_wren_cnt"}, s_wr_cnt[g], 2 * m_n);
    chk({tag, "_dec_wren_cnt"}, dec_wr_cnt[g], m_n);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_done"}, 32'(done_w[g]), 32'd1);
    end
    @(negedge clk); start_r[g] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, 32'(done_w[g]), 32'd0);
    chk({tag, "_idle_kv"}, 32'(kv_w[g]), 32'(m_kv));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad_pos;
    reset   = 1'b1;
    start_r = '0;
    load    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_kv", 32'(kv_w[0]), 32'd0);
    chk("rst_s_wren", 32'(s_wren_w[0]), 32'd0);
    chk("rst_dec_wren", 32'(dec_wren_w[0]), 32'd0);
    chk("rst_s_addr", 32'(s_addr_w[0]), 32'd0);
    chk("rst_s_wrdata", 32'(s_wrdata_w[0]), 32'd0);
    chk("rst_enc_addr", 32'(enc_addr_w[0]), 32'd0);
    chk("rst_dec_addr", 32'(dec_addr_w[0]), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Identity S, zero ciphertext, no text check; start held 10 cycles past done.
    set_identity();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'h00;
    run_check(0, 10, "ident4");
    chk("ident4_dec0", 32'(dec_mem[0][0]), 32'h02);
    chk("ident4_dec1", 32'(dec_mem[0][1]), 32'h05);
    chk("ident4_dec2", 32'(dec_mem[0][2]), 32'h07);
    chk("ident4_dec3", 32'(dec_mem[0][3]), 32'h0D);
    chk("ident4_s2", 32'(s_mem[0][2]), 32'h03);
    chk("ident4_s3", 32'(s_mem[0][3]), 32'h05);
    chk("ident4_s5", 32'(s_mem[0][5]), 32'h02);
    chk("ident4_s4", 32'(s_mem[0][4]), 32'h09);
    chk("ident4_s9", 32'(s_mem[0][9]), 32'h04);
    chk("ident4_edges32", last_edges, 32);
    chk("ident4_kv1", 32'(kv_w[0]), 32'd1);

    // Restart after a valid run: key_valid clears immediately, i starts at 1, j at 0.
    set_random_perm();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'($urandom_range(255, 0));
    run_check(0, 0, "restart");
    chk("restart_kv_first", 32'(last_kv1), 32'd0);
    chk("restart_i", 32'(last_a1), 32'd1);
    chk("restart_j", 32'(last_a3), 32'(m_s0[1]));

    // Reset asserted in WRITE_SI for two edges.
    set_identity();
    load_mem(0);
    @(negedge clk); start_r[0] = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    while (!s_wren_w[0] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst_reach_write", 32'(s_wren_w[0]), 32'd1);
    reset = 1'b1;
    start_r[0] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done", 32'(done_w[0]), 32'd0);
    chk("midrst_kv", 32'(kv_w[0]), 32'd0);
    chk("midrst_s_wren", 32'(s_wren_w[0]), 32'd0);
    chk("midrst_dec_wren", 32'(dec_wren_w[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_s_wren", 32'(s_wren_w[0]), 32'd0);
    set_identity();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'($urandom_range(255, 0));
    run_check(0, 0, "after_rst");

    // Text check aborts on the second byte (0x05).
    set_identity();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'($urandom_range(255, 0));
    m_enc[0] = 8'h63;
    m_enc[1] = 8'h00;
    run_check(1, 0, "abort4");
    chk("abort4_dec0", 32'(dec_mem[1][0]), 32'h61);
    chk("abort4_dec1", 32'(dec_mem[1][1]), 32'h05);
    chk("abort4_dec2", 32'(dec_mem[1][2]), 32'hEE);
    chk("abort4_dec3", 32'(dec_mem[1][3]), 32'hEE);
    chk("abort4_edges16", last_edges, 16);
    chk("abort4_kv0", 32'(kv_w[1]), 32'd0);
    chk("abort4_dec_wren2", dec_wr_cnt[1], 2);

    // Full 32-byte run decrypting to all 'a'.
    set_identity();
    gen_keystream();
    for (int k = 0; k < 32; k++) m_enc[k] = ks[k] ^ 8'h61;
    run_check(2, 0, "full32");
    for (int k = 0; k < 32; k++) chk("full32_dec_a", 32'(dec_mem[2][k]), 32'h61);
    chk("full32_edges256", last_edges, 256);
    chk("full32_s_wren64", s_wr_cnt[2], 64);
    chk("full32_kv1", 32'(kv_w[2]), 32'd1);

    // Character-class boundaries: space and 'z' accepted, backtick rejected.
    set_random_perm();
    gen_keystream();
    for (int k = 0; k < 32; k++) m_enc[k] = 8'($urandom_range(255, 0));
    m_enc[0] = ks[0] ^ 8'h20;
    m_enc[1] = ks[1] ^ 8'h7A;
    m_enc[2] = ks[2] ^ 8'h60;
    run_check(2, 0, "bound");
    chk("bound_edges24", last_edges, 24);
    chk("bound_kv0", 32'(kv_w[2]), 32'd0);
    chk("bound_dec2", 32'(dec_mem[2][2]), 32'h60);

    // Random permutations with mostly-text plaintext and an occasional bad byte.
    for (int r = 0; r < 4; r++) begin
      set_random_perm();
      gen_keystream();
      bad_pos = $urandom_range(45, 0);
      for (int k = 0; k < 32; k++)
        m_enc[k] = ks[k] ^ ((k == bad_pos) ? rand_bad() : rand_text());
      run_check(2, 0, "rand32");
    end
    for (int r = 0; r < 2; r++) begin
      set_random_perm();
      for (int k = 0; k < 32; k++) m_enc[k] = 8'($urandom_range(255, 0));
      run_check(r, 0, "rand4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prga_decrypt_op.md
Name: prga_decrypt_op

Overview:
- RC4 pseudo-random generation and decrypt stage; the direct downstream consumer of the key-schedule shuffle, which leaves the permuted 256x8 S memory behind.
- Walks S to produce one keystream byte per message byte, XORs it with the encrypted-message ROM, and writes plaintext to the decrypted-message RAM.
- Optionally flags the key as invalid the first time a decrypted byte is not lowercase ASCII or space, aborting the run early so the key-search controller can move to the next key.

Parameters:
MSG_LEN, 32, number of message bytes (1..32); enc/dec address width fixed at 5.
CHECK_ASCII, 1, 1 = abort on first byte outside {0x20, 0x61..0x7A}; 0 = always decrypt all bytes.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level request; sampled only in IDLE and DONE
done  out  1  high while in DONE
key_valid  out  1  result of last run; meaningful when done=1
s_addr  out  8  S memory address
s_wrdata  out  8  S memory write data
s_wren  out  1  S memory write enable
s_rddata  in  8  S memory read data; 1-cycle read latency
enc_addr  out  5  encrypted ROM address
enc_rddata  in  8  encrypted ROM data; 1-cycle read latency
dec_addr  out  5  decrypted RAM address
dec_wrdata  out  8  decrypted RAM write data
dec_wren  out  1  decrypted RAM write enable

Behaviour:
- Registers: i, j, si, sj (8b each), k (5b), state, key_valid.
- Arithmetic on i, j and si+sj is mod 256 (natural 8-bit wrap).
- Reset: state=IDLE; all registers 0; done=0, key_valid=0, all wren=0, all addresses and write data 0.
- Reset mid-run: IDLE on the next edge; no wren asserted in the following cycle; memory contents are not restored.
- Memory timing: address presented in cycle N is captured at the edge; read data is used in cycle N+1.
- Outputs are Moore-decoded from state and registers. Exception: dec_wrdata = s_rddata ^ enc_rddata, combinational in LATCH_F.
- States and transitions:
  - IDLE: on start=1, i<=1, j<=0, k<=0, key_valid<=0; go to READ_SI.
  - READ_SI: s_addr=i.
  - LATCH_SI: si<=s_rddata; j<=j+s_rddata.
  - READ_SJ: s_addr=j.
  - LATCH_SJ: sj<=s_rddata.
  - WRITE_SI: s_addr=i, s_wrdata=sj, s_wren=1.
  - WRITE_SJ: s_addr=j, s_wrdata=si, s_wren=1.
  - READ_F: s_addr=si+sj, enc_addr=k.
  - LATCH_F: dec_addr=k, dec_wrdata as above, dec_wren=1. The byte is always written, even if invalid. Next state:
    - if CHECK_ASCII and byte not in {0x20, 0x61..0x7A}: key_valid<=0, go to DONE;
    - else if k==MSG_LEN-1: key_valid<=1, go to DONE;
    - else k<=k+1, i<=i+1, go to READ_SI.
  - DONE: done=1; stays while start=1; IDLE on the next edge after start=0.
- Cost is exactly 8 cycles per byte.
  - Full run: done=1 after the 8*MSG_LEN-th edge following the edge that sampled start.
  - Abort at byte k: done=1 after 8*(k+1) edges.
- i==j (self-swap): both writes still issued; the data is consistent, so S is unchanged.
- s_wren pulses exactly twice per byte; dec_wren pulses exactly once per byte processed.
- key_valid holds through DONE and IDLE until the next start is accepted.
- start changes outside IDLE and DONE are ignored.

Test Plan:
- Reset: assert reset for 2 cycles mid-run (state WRITE_SI) -> next cycle done=0, key_valid=0, s_wren=0, dec_wren=0; a new start then runs normally.
- Identity S (s[n]=n), MSG_LEN=4, CHECK_ASCII=0, enc all 0x00 -> dec = 02,05,07,0D; S afterwards has s2=3, s3=5, s5=2, s4=9, s9=4; done=1 after 32 edges; key_valid=1.
- Identity S, MSG_LEN=4, CHECK_ASCII=1, enc = 63,00,xx,xx -> dec[0]=0x61, dec[1]=0x05 written; done after 16 edges; key_valid=0; dec_wren pulsed exactly twice; dec[2..3] untouched.
- Identity S, MSG_LEN=32, enc[k] = keystream[k]^0x61 (bench reference model) -> all dec=0x61, key_valid=1, done after 256 edges, 64 s_wren pulses.
- Space boundary: enc chosen so dec bytes are 0x20, 0x7A, 0x60 -> first two accepted, abort on 0x60, key_valid=0.
- Handshake: hold start high 10 cycles after done -> stays DONE, done=1. Drop start -> IDLE next edge. Restart -> key_valid clears in the first cycle of the run; registers i=1, j=0.
